// File: rtl/request_arbiter_8_if.sv
// Handshake/bus bundle between the round-robin request arbiter and its surroundings.
// master = arbiter side, slave = request sources plus grant consumer.
interface request_arbiter_8_if #(
    parameter int N = 8
);
    localparam int PW = $clog2(N);

    logic          enable;
    logic [N-1:0]  req;
    logic [N-1:0]  grant_onehot;
    logic          grant_valid;
    logic          grant_ready;
    logic [N-1:0]  pending;
    logic [PW-1:0] ptr;    // round-robin pointer, exported for observation

    modport master (
        input  enable,
        input  req,
        input  grant_ready,
        output grant_onehot,
        output grant_valid,
        output pending,
        output ptr
    );

    modport slave (
        output enable,
        output req,
        output grant_ready,
        input  grant_onehot,
        input  grant_valid,
        input  pending,
        input  ptr
    );
endinterface

// File: rtl/request_arbiter_8.sv
// Round-robin request arbiter producing a registered one-hot grant for an 8-to-3 encoder.
// Define ARB_EDGE_DETECT_EN for rising-edge request capture; default is level capture.
module request_arbiter_8 #(
    parameter int N = 8
) (
    input logic                 clk,
    input logic                 reset,
    request_arbiter_8_if.master bus
);
    localparam int            PW   = $clog2(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);
    localparam logic [N-1:0]  ONE  = {{(N - 1){1'b0}}, 1'b1};

    // Handshake: a transfer happens at an edge where grant_valid & grant_ready; while
    // grant_valid is high and grant_ready is low, grant_onehot and ptr hold steady.
    logic [N-1:0]  pending_q;
    logic [N-1:0]  grant_q;
    logic          valid_q;
    logic [PW-1:0] ptr_q;

    logic [N-1:0]  captured;
    logic [N-1:0]  sel_onehot;
    logic [N-1:0]  pending_nxt;
    logic [PW-1:0] sel;
    logic [PW-1:0] idx;
    logic          found;
    logic          transfer;
    logic          load;

`ifdef ARB_EDGE_DETECT_EN
    logic [N-1:0] req_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_prev <= '0;
        end else begin
            req_prev <= bus.req;
        end
    end

    assign captured = bus.req & ~req_prev;
`else
    assign captured = bus.req;
`endif

    // First set pending bit at or above ptr, wrapping explicitly mod N.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr_q) + i) % N);
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign sel_onehot  = ONE << sel;
    assign transfer    = valid_q & bus.grant_ready;
    assign load        = (!valid_q || transfer) && bus.enable && found;
    // A capture in the same edge as the grant re-sets the bit: set wins over clear.
    assign pending_nxt = (pending_q & ~(load ? sel_onehot : '0)) | captured;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            ptr_q     <= '0;
        end else begin
            pending_q <= pending_nxt;
            if (load) begin
                grant_q <= sel_onehot;
                valid_q <= 1'b1;
                ptr_q   <= (sel == LAST) ? '0 : sel + 1'b1;
            end else if (transfer) begin
                grant_q <= '0;
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.grant_onehot = grant_q;
    assign bus.grant_valid  = valid_q;
    assign bus.pending      = pending_q;
    assign bus.ptr          = ptr_q;
endmodule

// File: tb/tb_request_arbiter_8.sv
// Directed bench for request_arbiter_8: stimulus pushes expected grants into a queue,
// a negedge monitor pops and compares on every transfer.
module tb_request_arbiter_8;
    logic clk;
    logic reset;

    request_arbiter_8_if #(.N(8)) bus ();

    request_arbiter_8 #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] exp_q[$];
    int vectors = 0;
    int errors  = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.grant_valid === 1'b1 && bus.grant_ready === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant: got %0h expected none at %0t", bus.grant_onehot, $time);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (bus.grant_onehot !== e) begin
                        errors++;
                        $display("FAIL grant_order: got %0h expected %0h at %0t", bus.grant_onehot, e, $time);
                    end
                end
            end else if (bus.grant_valid === 1'b0 && bus.grant_onehot !== 8'h00) begin
                vectors++;
                errors++;
                $display("FAIL idle_zero: got %0h expected 0 at %0t", bus.grant_onehot, $time);
            end
        end
    end

    // stimulus
    initial begin
        reset           = 1'b1;
        bus.req         = 8'hFF;
        bus.enable      = 1'b1;
        bus.grant_ready = 1'b1;

        // reset / idle
        for (int c = 0; c < 2; c++) begin
            tick();
            check("reset_pending", bus.pending, 8'h00);
            check("reset_valid", bus.grant_valid, 1'b0);
            check("reset_grant", bus.grant_onehot, 8'h00);
        end
        for (int b = 0; b < 8; b++) exp_q.push_back(8'h01 << b);
        reset = 1'b0;
        tick();
        bus.req = 8'h00;
        tick();
        check("post_reset_grant", bus.grant_onehot, 8'h01);
        repeat (9) tick();
        check("post_reset_drain", bus.grant_valid, 1'b0);

        // round-robin order
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h80);
        bus.req = 8'b1010_0100;
        tick();
        bus.req = 8'h00;
        check("rr_pending", bus.pending, 8'hA4);
        tick();
        check("rr_g0", bus.grant_onehot, 8'h04);
        tick();
        check("rr_g1", bus.grant_onehot, 8'h20);
        tick();
        check("rr_g2", bus.grant_onehot, 8'h80);
        tick();
        check("rr_done", bus.grant_valid, 1'b0);

        // backpressure
        bus.grant_ready = 1'b0;
        bus.req = 8'h08;
        tick();
        bus.req = 8'h00;
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", bus.grant_valid, 1'b1);
            check("bp_grant", bus.grant_onehot, 8'h08);
            tick();
        end
        exp_q.push_back(8'h08);
        bus.grant_ready = 1'b1;
        tick();
        check("bp_release", bus.grant_valid, 1'b0);

        // wrap-around
        exp_q.push_back(8'h40);
        bus.req = 8'h40;
        tick();
        bus.req = 8'h00;
        tick();
        check("wrap_ptr", bus.ptr, 3'd7);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h40);
        bus.req = 8'b0100_0011;
        tick();
        bus.req = 8'h00;
        check("wrap_pending", bus.pending, 8'h43);
        check("wrap_gap", bus.grant_valid, 1'b0);
        tick();
        check("wrap_g0", bus.grant_onehot, 8'h01);
        tick();
        check("wrap_g1", bus.grant_onehot, 8'h02);
        tick();
        check("wrap_g2", bus.grant_onehot, 8'h40);
        tick();
        check("wrap_done", bus.grant_valid, 1'b0);

        // enable gating
        bus.enable = 1'b0;
        bus.req = 8'h10;
        tick();
        bus.req = 8'h00;
        repeat (3) tick();
        check("en_no_grant", bus.grant_valid, 1'b0);
        check("en_pending", bus.pending, 8'h10);
        exp_q.push_back(8'h10);
        bus.enable = 1'b1;
        tick();
        check("en_grant", bus.grant_onehot, 8'h10);
        tick();
        check("en_done", bus.grant_valid, 1'b0);

`ifdef ARB_EDGE_DETECT_EN
        // held-high line yields one grant
        exp_q.push_back(8'h04);
        bus.req = 8'h04;
        repeat (10) tick();
        bus.req = 8'h00;
        repeat (3) tick();
        check("edge_valid", bus.grant_valid, 1'b0);
        check("edge_pending", bus.pending, 8'h00);
`else
        // same-edge set/clear: held line re-granted
        for (int c = 0; c < 4; c++) exp_q.push_back(8'h04);
        bus.req = 8'h04;
        tick();
        check("sc_pending", bus.pending, 8'h04);
        tick();
        check("sc_grant", bus.grant_onehot, 8'h04);
        tick();
        check("sc_set_wins", bus.pending, 8'h04);
        tick();
        bus.req = 8'h00;
        tick();
        tick();
        check("sc_valid", bus.grant_valid, 1'b0);
        check("sc_pending_clear", bus.pending, 8'h00);
`endif

        // reset mid-operation discards grant and pending
        bus.grant_ready = 1'b0;
        bus.req = 8'hFF;
        tick();
        bus.req = 8'h00;
        tick();
        check("mid_valid_before", bus.grant_valid, 1'b1);
        reset = 1'b1;
        tick();
        check("mid_valid", bus.grant_valid, 1'b0);
        check("mid_pending", bus.pending, 8'h00);
        check("mid_grant", bus.grant_onehot, 8'h00);
        reset = 1'b0;
        bus.grant_ready = 1'b1;
        repeat (3) tick();
        check("mid_idle", bus.grant_valid, 1'b0);

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
